// File: rtl/seg7_encoder.sv
// seg7_encoder: recovers the hex digit shown on an active-low 7-segment bus.
// A pattern must hold for STABLE_CYCLES edges before it is accepted. Each new
// non-blank pattern is decoded and offered downstream through a one-entry
// VALID/READY buffer.
// Optional feature macro: SEG7_ERRCNT_EN adds the saturating ERR_COUNT port.
module seg7_encoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned STABLE_W      = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [6:0] HEX,
    output logic [3:0] NIB,
    output logic       ERR,
    output logic       VALID,
    input  logic       READY,
    output logic       DROP
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [7:0] ERR_COUNT
`endif
);

    localparam int unsigned HEX_W   = 7;
    localparam int unsigned NIB_W   = 4;
    localparam logic [HEX_W-1:0] BLANK = 7'h7F;
    localparam logic [STABLE_W-1:0] CNT_MAX    = STABLE_W'(STABLE_CYCLES);
    localparam logic [STABLE_W-1:0] CNT_ACCEPT = STABLE_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t           state_q;
    buf_state_t           state_d;
    logic [HEX_W-1:0]     hex_q;
    logic [HEX_W-1:0]     last_acc;
    logic [STABLE_W-1:0]  cnt;
    logic                 accept_c;
    logic                 emit_c;
    logic                 load_c;
    logic                 drop_c;
    logic [NIB_W-1:0]     dec_nib_c;
    logic                 dec_err_c;

    // Exact-match decode of the a..g pattern; anything unknown is an error digit.
    function automatic logic [NIB_W:0] decode(input logic [HEX_W-1:0] pat);
        logic [NIB_W:0] res;
        res = {1'b1, 4'h0};
        case (pat)
            7'b0000001: res = {1'b0, 4'h0};
            7'b1001111: res = {1'b0, 4'h1};
            7'b0010010: res = {1'b0, 4'h2};
            7'b0000110: res = {1'b0, 4'h3};
            7'b1001100: res = {1'b0, 4'h4};
            7'b0100100: res = {1'b0, 4'h5};
            7'b0100000: res = {1'b0, 4'h6};
            7'b0001111: res = {1'b0, 4'h7};
            7'b0000000: res = {1'b0, 4'h8};
            7'b0000100: res = {1'b0, 4'h9};
            7'b0001000: res = {1'b0, 4'hA};
            7'b1100000: res = {1'b0, 4'hB};
            7'b0110001: res = {1'b0, 4'hC};
            7'b1000010: res = {1'b0, 4'hD};
            7'b0110000: res = {1'b0, 4'hE};
            7'b0111000: res = {1'b0, 4'hF};
            default:    res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

    // Decode the live bus; only used when a pattern is accepted.
    always_comb begin
        dec_nib_c = 4'h0;
        dec_err_c = 1'b0;
        {dec_err_c, dec_nib_c} = decode(HEX);
    end

    // A pattern is accepted once, on the cycle its hold count reaches the threshold.
    always_comb begin
        accept_c = 1'b0;
        emit_c   = 1'b0;
        if ((HEX == hex_q) && (cnt == CNT_ACCEPT) && (HEX != last_acc)) begin
            accept_c = 1'b1;
        end
        // Blank is tracked as a distinct pattern but never handed downstream.
        emit_c = accept_c && (HEX != BLANK);
    end

    // Stability filter: sample the bus and count edges it has held still.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex_q    <= BLANK;
            last_acc <= BLANK;
            cnt      <= '0;
        end else begin
            hex_q <= HEX;
            if (HEX != hex_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + STABLE_W'(1);
            end
            if (accept_c) begin
                last_acc <= HEX;
            end
        end
    end

    // Output buffer state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output buffer next state: a new digit always lands, a transfer empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (emit_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (emit_c) begin
                    state_d = FULL;
                end else if (READY) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output buffer actions: load on every emit, flag overwrite of an unconsumed digit.
    always_comb begin
        load_c = 1'b0;
        drop_c = 1'b0;
        if (emit_c) begin
            load_c = 1'b1;
            if ((state_q == FULL) && !READY) begin
                drop_c = 1'b1;
            end
        end
    end

    // Registered digit, error qualifier and drop pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            NIB  <= '0;
            ERR  <= 1'b0;
            DROP <= 1'b0;
        end else begin
            DROP <= drop_c;
            if (load_c) begin
                NIB <= dec_nib_c;
                ERR <= dec_err_c;
            end
        end
    end

    assign VALID = (state_q == FULL);

`ifdef SEG7_ERRCNT_EN
    // Saturating count of emitted error digits, including ones later dropped.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ERR_COUNT <= '0;
        end else if (emit_c && dec_err_c && (ERR_COUNT != 8'hFF)) begin
            ERR_COUNT <= ERR_COUNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_encoder.sv
// Directed bench for seg7_encoder. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the DUT edge.
module tb_seg7_encoder;

    logic       clock;
    logic       resetn;
    logic [6:0] HEX;
    logic [3:0] NIB;
    logic       ERR;
    logic       VALID;
    logic       READY;
    logic       DROP;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] ERR_COUNT;
`endif

    int n_tests;
    int n_fail;

    // Transfer / drop monitor, only ever incremented here.
    int         xfers;
    int         drops;
    logic [3:0] last_nib;
    logic       last_err;
    logic       seen_three;

    int x0;
    int d0;

    seg7_encoder #(
        .STABLE_CYCLES(4),
        .STABLE_W     (4)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .HEX   (HEX),
        .NIB   (NIB),
        .ERR   (ERR),
        .VALID (VALID),
        .READY (READY),
        .DROP  (DROP)
`ifdef SEG7_ERRCNT_EN
        ,
        .ERR_COUNT(ERR_COUNT)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        xfers      = 0;
        drops      = 0;
        last_nib   = 4'h0;
        last_err   = 1'b0;
        seen_three = 1'b0;
    end

    always @(posedge clock) begin
        if (resetn && VALID && READY) begin
            xfers    = xfers + 1;
            last_nib = NIB;
            last_err = ERR;
        end
        if (resetn && DROP) drops = drops + 1;
        if (resetn && VALID && !ERR && NIB == 4'h3) seen_three = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        HEX     = 7'h7F;
        READY   = 1'b0;
        wait_neg(2);

        // Reset state
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_nib",   32'(NIB),   32'd0);
        check("rst_err",   32'(ERR),   32'd0);
        check("rst_drop",  32'(DROP),  32'd0);
`ifdef SEG7_ERRCNT_EN
        check("rst_errcnt", 32'(ERR_COUNT), 32'd0);
`endif
        resetn = 1'b1;
        wait_neg(1);

        // Digit 2 with READY high: VALID appears after the 5th edge, for one cycle
        READY = 1'b1;
        HEX   = 7'b0010010;
        x0    = xfers;
        wait_neg(4);
        check("t2_not_yet", 32'(VALID), 32'd0);
        wait_neg(1);
        check("t2_valid", 32'(VALID), 32'd1);
        check("t2_nib",   32'(NIB),   32'h2);
        check("t2_err",   32'(ERR),   32'd0);
        wait_neg(1);
        check("t2_valid_gone", 32'(VALID), 32'd0);
        wait_neg(6);
        check("t2_xfers", 32'(xfers - x0), 32'd1);

        // Short 3 glitch followed by a held 5: only 5 emerges
        HEX = 7'b0000110;
        x0  = xfers;
        wait_neg(2);
        HEX = 7'b0100100;
        wait_neg(10);
        check("t3_xfers", 32'(xfers - x0), 32'd1);
        check("t3_nib",   32'(last_nib),   32'h5);
        check("t3_no3",   32'(seen_three), 32'd0);

        // Illegal pattern decodes to an error digit
        HEX = 7'b1111110;
        x0  = xfers;
        wait_neg(10);
        check("t4_xfers", 32'(xfers - x0), 32'd1);
        check("t4_err",   32'(last_err),   32'd1);
        check("t4_nib",   32'(last_nib),   32'h0);
`ifdef SEG7_ERRCNT_EN
        check("t4_errcnt", 32'(ERR_COUNT), 32'd1);
`endif

        // READY low: 7 is overwritten by 8 with a single DROP pulse
        READY = 1'b0;
        HEX   = 7'b0001111;
        x0    = xfers;
        d0    = drops;
        wait_neg(5);
        check("t5_valid7", 32'(VALID), 32'd1);
        check("t5_nib7",   32'(NIB),   32'h7);
        wait_neg(1);
        HEX = 7'b0000000;
        wait_neg(4);
        check("t5_hold7", 32'(NIB),  32'h7);
        check("t5_nodrop_yet", 32'(DROP), 32'd0);
        wait_neg(1);
        check("t5_nib8",  32'(NIB),   32'h8);
        check("t5_drop",  32'(DROP),  32'd1);
        check("t5_valid8", 32'(VALID), 32'd1);
        wait_neg(1);
        check("t5_drop_end", 32'(DROP), 32'd0);
        wait_neg(4);
        check("t5_drops", 32'(drops - d0), 32'd1);
        check("t5_no_xfer", 32'(xfers - x0), 32'd0);
        READY = 1'b1;
        wait_neg(1);
        check("t5_emptied", 32'(VALID), 32'd0);
        check("t5_xfer", 32'(xfers - x0), 32'd1);
        check("t5_xfer_nib", 32'(last_nib), 32'h8);

        // F held long emits once; blank then F again emits a second time
        HEX = 7'b0111000;
        x0  = xfers;
        wait_neg(20);
        check("t6_once", 32'(xfers - x0), 32'd1);
        check("t6_nibF", 32'(last_nib),   32'hF);
        HEX = 7'h7F;
        wait_neg(6);
        check("t6_blank_silent", 32'(xfers - x0), 32'd1);
        HEX = 7'b0111000;
        wait_neg(8);
        check("t6_twice", 32'(xfers - x0), 32'd2);
        check("t6_nibF2", 32'(last_nib),   32'hF);

        // Asynchronous reset with a pending digit clears outputs at once
        READY = 1'b0;
        HEX   = 7'b1001111;
        wait_neg(6);
        check("t1_pending", 32'(VALID), 32'd1);
        check("t1_nib1",    32'(NIB),   32'h1);
        #2 resetn = 1'b0;
        #1;
        check("t1_valid", 32'(VALID), 32'd0);
        check("t1_nib",   32'(NIB),   32'd0);
        check("t1_err",   32'(ERR),   32'd0);
        check("t1_drop",  32'(DROP),  32'd0);
`ifdef SEG7_ERRCNT_EN
        check("t1_errcnt", 32'(ERR_COUNT), 32'd0);
`endif
        wait_neg(2);
        resetn = 1'b1;
        // After reset the held 1 is new again and re-emits
        wait_neg(6);
        check("t1_reemit", 32'(VALID), 32'd1);
        check("t1_reemit_nib", 32'(NIB), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
